// File: rtl/writeback_queue.sv
// writeback_queue: multi-lane writeback stage.
// Up to LANES completed instructions enter per cycle. Load data is extracted
// and sign/zero extended on the way in. Entries sit in an in-order circular
// queue and retire up to WPORTS per cycle onto the regfile ports. At most one
// CSR write retires per cycle.
module writeback_queue #(
    parameter int LANES  = 2,
    parameter int WPORTS = 2,
    parameter int DEPTH  = 8,
    parameter int XLEN   = 64
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [LANES-1:0]            in_valid,
    input  logic [LANES*XLEN-1:0]       in_result,
    input  logic [LANES*XLEN-1:0]       in_rdata,
    input  logic [LANES-1:0]            in_memread,
    input  logic [LANES*2-1:0]          in_msize,
    input  logic [LANES-1:0]            in_unsigned,
    input  logic [LANES-1:0]            in_regwrite,
    input  logic [LANES*5-1:0]          in_writereg,
    input  logic [LANES-1:0]            in_csrwrite,
    input  logic [LANES*12-1:0]         in_csr_addr,
    input  logic [LANES*XLEN-1:0]       in_csr_wd,
    output logic                        in_ready,
    input  logic                        stall,
    output logic [WPORTS-1:0]           rf_valid,
    output logic [WPORTS*5-1:0]         rf_wa,
    output logic [WPORTS*XLEN-1:0]      rf_wd,
    output logic                        csr_valid,
    output logic [11:0]                 csr_wa,
    output logic [XLEN-1:0]             csr_wd,
    output logic [$clog2(WPORTS):0]     retire_cnt,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);   // pointer width
    localparam int CW = AW + 1;          // occupancy width (0..DEPTH)
    localparam int RW = $clog2(WPORTS) + 1;

    // One queued writeback, data already extracted/extended.
    typedef struct packed {
        logic            rw;
        logic [4:0]      wr;
        logic            csr;
        logic [11:0]     caddr;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] cwd;
    } entry_t;

    // Select the addressed byte/half/word from an aligned 64-bit read and
    // extend it. Offset bits below the access size are ignored.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] rdata,
        input logic [1:0]      sz,
        input logic            uns,
        input logic [2:0]      off
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     w;
        logic [XLEN-1:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[2:1], 4'b0000} +: 16];
        w = rdata[{off[2], 5'b00000} +: 32];
        case (sz)
            2'd0:    r = uns ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
            2'd1:    r = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            2'd2:    r = uns ? {{(XLEN-32){1'b0}}, w} : {{(XLEN-32){w[31]}}, w};
            default: r = rdata;
        endcase
        return r;
    endfunction

    entry_t            r_mem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    entry_t                   w_new      [LANES];
    logic [LANES-1:0][CW-1:0] w_lane_pos;
    logic [CW-1:0]            w_enq_raw;
    logic [CW-1:0]            w_enq_n;
    logic                     w_enq_go;

    entry_t                   w_ent      [WPORTS];
    logic [WPORTS-1:0]        w_take;
    logic [WPORTS-1:0]        w_wr_ok;
    logic [RW-1:0]            w_ret_n;

    // Admission looks only at registered occupancy; a retire in the same
    // cycle does not free space for this cycle's group.
    assign in_ready = (r_count <= CW'(DEPTH - LANES));
    assign empty    = (r_count == '0);
    assign w_enq_go = in_ready;
    assign w_enq_n  = w_enq_go ? w_enq_raw : '0;

    // Build the entry each lane would store (load extraction done here).
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        always_comb begin
            w_new[i].rw    = in_regwrite[i];
            w_new[i].wr    = in_writereg[i*5 +: 5];
            w_new[i].csr   = in_csrwrite[i];
            w_new[i].caddr = in_csr_addr[i*12 +: 12];
            w_new[i].cwd   = in_csr_wd[i*XLEN +: XLEN];
            w_new[i].wd    = in_memread[i]
                           ? load_extract(in_rdata[i*XLEN +: XLEN], in_msize[i*2 +: 2],
                                          in_unsigned[i], in_result[i*XLEN +: 3])
                           : in_result[i*XLEN +: XLEN];
        end
    end

    // Compact valid lanes: each lane's slot is the number of valid older lanes.
    always_comb begin
        w_enq_raw = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_pos[i] = w_enq_raw;
            if (in_valid[i])
                w_enq_raw = w_enq_raw + CW'(1);
        end
    end

    // Write accepted lanes into storage at tail (contents need no reset).
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (resetn && w_enq_go && in_valid[i])
                r_mem[r_tail + w_lane_pos[i][AW-1:0]] <= w_new[i];
    end

    // Candidate entries for each write port, starting at head.
    always_comb begin
        for (int k = 0; k < WPORTS; k++)
            w_ent[k] = r_mem[r_head + AW'(k)];
    end

    // Retire group: longest in-order prefix bounded by ports, occupancy and
    // a single CSR write; a second CSR entry closes the group before it.
    always_comb begin
        logic open_q;
        logic csr_seen;
        open_q   = resetn && !stall;
        csr_seen = 1'b0;
        w_take   = '0;
        w_ret_n  = '0;
        for (int k = 0; k < WPORTS; k++) begin
            if (open_q && (CW'(k) < r_count) && !(w_ent[k].csr && csr_seen)) begin
                w_take[k] = 1'b1;
                w_ret_n   = w_ret_n + RW'(1);
                if (w_ent[k].csr)
                    csr_seen = 1'b1;
            end else begin
                open_q = 1'b0;
            end
        end
    end

    // A retiring entry writes the regfile only if it targets a non-zero reg.
    always_comb begin
        for (int k = 0; k < WPORTS; k++)
            w_wr_ok[k] = w_take[k] && w_ent[k].rw && (w_ent[k].wr != 5'd0);
    end

    // Regfile ports: suppress an older write shadowed by a younger one to the
    // same register in the same group so the regfile sees only the last writer.
    always_comb begin
        rf_valid = '0;
        rf_wa    = '0;
        rf_wd    = '0;
        for (int k = 0; k < WPORTS; k++) begin
            rf_valid[k] = w_wr_ok[k];
            for (int j = k + 1; j < WPORTS; j++)
                if (w_wr_ok[j] && (w_ent[j].wr == w_ent[k].wr))
                    rf_valid[k] = 1'b0;
            if (rf_valid[k]) begin
                rf_wa[k*5 +: 5]       = w_ent[k].wr;
                rf_wd[k*XLEN +: XLEN] = w_ent[k].wd;
            end
        end
    end

    // CSR port carries the (at most one) CSR entry in the retire group.
    always_comb begin
        csr_valid = 1'b0;
        csr_wa    = '0;
        csr_wd    = '0;
        for (int k = 0; k < WPORTS; k++) begin
            if (w_take[k] && w_ent[k].csr) begin
                csr_valid = 1'b1;
                csr_wa    = w_ent[k].caddr;
                csr_wd    = w_ent[k].cwd;
            end
        end
    end

    assign retire_cnt = w_ret_n;

    // Queue pointers and occupancy; reset discards every entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_ret_n);
            r_tail  <= r_tail + w_enq_n[AW-1:0];
            r_count <= r_count + w_enq_n - CW'(w_ret_n);
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized + directed bench for writeback_queue against a queue-based model.
module tb_writeback_queue;

    localparam int LANES  = 2;
    localparam int WPORTS = 2;
    localparam int DEPTH  = 8;
    localparam int XLEN   = 64;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [LANES-1:0]       in_valid;
    logic [LANES*XLEN-1:0]  in_result;
    logic [LANES*XLEN-1:0]  in_rdata;
    logic [LANES-1:0]       in_memread;
    logic [LANES*2-1:0]     in_msize;
    logic [LANES-1:0]       in_unsigned;
    logic [LANES-1:0]       in_regwrite;
    logic [LANES*5-1:0]     in_writereg;
    logic [LANES-1:0]       in_csrwrite;
    logic [LANES*12-1:0]    in_csr_addr;
    logic [LANES*XLEN-1:0]  in_csr_wd;
    logic                   in_ready;
    logic                   stall;
    logic [WPORTS-1:0]      rf_valid;
    logic [WPORTS*5-1:0]    rf_wa;
    logic [WPORTS*XLEN-1:0] rf_wd;
    logic                   csr_valid;
    logic [11:0]            csr_wa;
    logic [XLEN-1:0]        csr_wd;
    logic [$clog2(WPORTS):0] retire_cnt;
    logic                   empty;

    writeback_queue #(.LANES(LANES), .WPORTS(WPORTS), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_result(in_result),
        .in_rdata(in_rdata), .in_memread(in_memread), .in_msize(in_msize),
        .in_unsigned(in_unsigned), .in_regwrite(in_regwrite), .in_writereg(in_writereg),
        .in_csrwrite(in_csrwrite), .in_csr_addr(in_csr_addr), .in_csr_wd(in_csr_wd),
        .in_ready(in_ready), .stall(stall), .rf_valid(rf_valid), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .csr_valid(csr_valid), .csr_wa(csr_wa), .csr_wd(csr_wd),
        .retire_cnt(retire_cnt), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rw;
        bit [4:0]  wr;
        bit        csr;
        bit [11:0] ca;
        bit [63:0] d;
        bit [63:0] cd;
    } ment_t;

    ment_t mq[$];
    int    tests = 0;
    int    fails = 0;
    bit    chk_en = 0;
    localparam logic [63:0] LD = 64'h8877_6655_4433_2281;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Load extraction from the rules: aligned offset, shift, mask, extend.
    function automatic logic [63:0] ext(input logic [63:0] rd, input int sz, input bit u, input int off);
        int bytes, o;
        logic [63:0] v, m;
        if (sz == 3) return rd;
        bytes = 1 << sz;
        o = (off / bytes) * bytes;
        v = rd >> (8 * o);
        m = (64'd1 << (8 * bytes)) - 64'd1;
        v = v & m;
        if (!u && v[8*bytes-1]) v = v | ~m;
        return v;
    endfunction

    // Number of queued entries that retire this cycle.
    function automatic int grp_len(input bit stl, input bit rn);
        int n;
        bit c;
        n = 0;
        c = 0;
        if (stl || !rn) return 0;
        while (n < WPORTS && n < mq.size()) begin
            if (mq[n].csr) begin
                if (c) break;
                c = 1;
            end
            n++;
        end
        return n;
    endfunction

    task automatic compare_all();
        int n;
        bit ok;
        logic [WPORTS-1:0]      ev;
        logic [WPORTS*5-1:0]    ewa;
        logic [WPORTS*64-1:0]   ewd;
        logic                   ecv;
        logic [11:0]            eca;
        logic [63:0]            ecd;
        n = grp_len(stall, resetn);
        ev = '0; ewa = '0; ewd = '0; ecv = 0; eca = '0; ecd = '0;
        for (int k = 0; k < n; k++) begin
            ok = mq[k].rw && (mq[k].wr != 0);
            for (int j = k + 1; j < n; j++)
                if (mq[j].rw && mq[j].wr == mq[k].wr) ok = 0;
            if (ok) begin
                ev[k] = 1'b1;
                ewa[k*5 +: 5] = mq[k].wr;
                ewd[k*64 +: 64] = mq[k].d;
            end
            if (mq[k].csr) begin
                ecv = 1'b1;
                eca = mq[k].ca;
                ecd = mq[k].cd;
            end
        end
        chk("in_ready",   128'(in_ready),   128'(mq.size() <= DEPTH - LANES));
        chk("empty",      128'(empty),      128'(mq.size() == 0));
        chk("retire_cnt", 128'(retire_cnt), 128'(n));
        chk("rf_valid",   128'(rf_valid),   128'(ev));
        chk("rf_wa",      128'(rf_wa),      128'(ewa));
        chk("rf_wd",      128'(rf_wd),      128'(ewd));
        chk("csr_valid",  128'(csr_valid),  128'(ecv));
        chk("csr_wa",     128'(csr_wa),     128'(eca));
        chk("csr_wd",     128'(csr_wd),     128'(ecd));
    endtask

    task automatic model_update();
        int  n;
        bit  rdy;
        ment_t e;
        n   = grp_len(stall, resetn);
        rdy = (mq.size() <= DEPTH - LANES);
        if (!resetn) begin
            mq.delete();
        end else begin
            repeat (n) void'(mq.pop_front());
            if (rdy) begin
                for (int i = 0; i < LANES; i++) begin
                    if (in_valid[i]) begin
                        e.rw  = in_regwrite[i];
                        e.wr  = in_writereg[i*5 +: 5];
                        e.csr = in_csrwrite[i];
                        e.ca  = in_csr_addr[i*12 +: 12];
                        e.cd  = in_csr_wd[i*64 +: 64];
                        e.d   = in_memread[i]
                              ? ext(in_rdata[i*64 +: 64], int'(in_msize[i*2 +: 2]),
                                    in_unsigned[i], int'(in_result[i*64 +: 3]))
                              : in_result[i*64 +: 64];
                        mq.push_back(e);
                    end
                end
            end
            if (mq.size() > DEPTH) begin
                fails++;
                $display("FAIL model_overflow: got %0d entries, expected at most %0d", mq.size(), DEPTH);
            end
        end
    endtask

    // One cycle: inputs already driven; check, clock edge, model step.
    task automatic cyc();
        #1;
        if (chk_en) compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_in();
        in_valid = '0; in_result = '0; in_rdata = '0; in_memread = '0;
        in_msize = '0; in_unsigned = '0; in_regwrite = '0; in_writereg = '0;
        in_csrwrite = '0; in_csr_addr = '0; in_csr_wd = '0;
    endtask

    task automatic set_lane(input int i, input logic rw, input logic [4:0] rd,
                            input logic [63:0] res, input logic mr, input logic [1:0] sz,
                            input logic u, input logic [63:0] rdat, input logic cw,
                            input logic [11:0] ca, input logic [63:0] cd);
        in_valid[i] = 1'b1;
        in_regwrite[i] = rw;
        in_writereg[i*5 +: 5] = rd;
        in_result[i*64 +: 64] = res;
        in_memread[i] = mr;
        in_msize[i*2 +: 2] = sz;
        in_unsigned[i] = u;
        in_rdata[i*64 +: 64] = rdat;
        in_csrwrite[i] = cw;
        in_csr_addr[i*12 +: 12] = ca;
        in_csr_wd[i*64 +: 64] = cd;
    endtask

    task automatic load_chk(input string nm, input logic [1:0] sz, input logic u,
                            input logic [63:0] off, input logic [63:0] exp);
        clear_in();
        set_lane(0, 1, 5'd7, off, 1, sz, u, LD, 0, 12'h0, 64'h0);
        cyc();
        clear_in();
        chk({nm, "_valid"}, 128'(rf_valid), 128'(2'b01));
        chk(nm, 128'(rf_wd[63:0]), 128'(exp));
        cyc();
    endtask

    int seq;

    initial begin
        resetn = 1'b0;
        stall  = 1'b0;
        clear_in();
        @(negedge clk);
        cyc();
        cyc();
        chk_en = 1;
        resetn = 1'b1;

        // model pinned against hand-computed extractions
        chk("model_lb",  128'(ext(LD, 0, 0, 0)), 128'(64'hFFFF_FFFF_FFFF_FF81));
        chk("model_lhu", 128'(ext(LD, 1, 1, 7)), 128'(64'h8877));
        chk("model_ld",  128'(ext(LD, 3, 1, 0)), 128'(LD));

        // reset state
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_empty",    128'(empty),    128'(1));
        chk("rst_rf_valid", 128'(rf_valid), 128'(0));
        chk("rst_csr_valid",128'(csr_valid),128'(0));
        cyc();

        // single ALU writeback
        set_lane(0, 1, 5'd5, 64'h1234, 0, 2'd0, 0, 64'h0, 0, 12'h0, 64'h0);
        cyc();
        clear_in();
        chk("alu_valid", 128'(rf_valid), 128'(2'b01));
        chk("alu_wa",    128'(rf_wa[4:0]), 128'(5));
        chk("alu_wd",    128'(rf_wd[63:0]), 128'(64'h1234));
        chk("alu_cnt",   128'(retire_cnt), 128'(1));
        cyc();
        chk("alu_empty", 128'(empty), 128'(1));

        // loads
        load_chk("lb",  2'd0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FF81);
        load_chk("lbu", 2'd0, 1, 64'd0, 64'h81);
        load_chk("lh",  2'd1, 0, 64'd6, 64'hFFFF_FFFF_FFFF_8877);
        load_chk("lwu", 2'd2, 1, 64'd4, 64'h8877_6655);

        // fill with stall, then stream across several pointer wraps
        seq = 1;
        stall = 1'b1;
        clear_in();
        set_lane(0, 1, 5'(seq % 31 + 1), 64'(seq), 0, 0, 0, 0, 0, 0, 0);
        seq++;
        cyc();
        for (int c = 0; c < 3; c++) begin
            clear_in();
            for (int i = 0; i < LANES; i++) begin
                set_lane(i, 1, 5'(seq % 31 + 1), 64'(seq), 0, 0, 0, 0, 0, 0, 0);
                seq++;
            end
            cyc();
            if (c == 1) chk("fill5_ready", 128'(in_ready), 128'(1));
        end
        chk("fill7_ready", 128'(in_ready), 128'(0));
        chk("fill7_empty", 128'(empty), 128'(0));
        cyc();
        chk("fill7_hold", 128'(in_ready), 128'(0));
        stall = 1'b0;
        for (int c = 0; c < 30; c++) begin
            clear_in();
            for (int i = 0; i < LANES; i++) begin
                set_lane(i, 1, 5'(seq % 31 + 1), 64'(seq), 0, 0, 0, 0, 0, 0, 0);
                seq++;
            end
            cyc();
        end
        clear_in();
        repeat (6) cyc();
        chk("drain_empty", 128'(empty), 128'(1));

        // same-group hazards
        set_lane(0, 1, 5'd3, 64'hAAAA, 0, 0, 0, 0, 0, 0, 0);
        set_lane(1, 1, 5'd3, 64'hBBBB, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        clear_in();
        chk("waw_valid", 128'(rf_valid), 128'(2'b10));
        chk("waw_wa",    128'(rf_wa[9:5]), 128'(3));
        chk("waw_wd",    128'(rf_wd[127:64]), 128'(64'hBBBB));
        cyc();
        set_lane(0, 1, 5'd0, 64'h55, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        clear_in();
        chk("x0_valid", 128'(rf_valid), 128'(0));
        chk("x0_cnt",   128'(retire_cnt), 128'(1));
        cyc();

        // back-to-back CSR writes split across cycles
        set_lane(0, 0, 5'd0, 64'h0, 0, 0, 0, 0, 1, 12'h300, 64'hC0DE_0300);
        set_lane(1, 0, 5'd0, 64'h0, 0, 0, 0, 0, 1, 12'h305, 64'hC0DE_0305);
        cyc();
        clear_in();
        chk("csr0_valid", 128'(csr_valid), 128'(1));
        chk("csr0_wa",    128'(csr_wa), 128'(12'h300));
        chk("csr0_wd",    128'(csr_wd), 128'(64'hC0DE_0300));
        chk("csr0_cnt",   128'(retire_cnt), 128'(1));
        cyc();
        chk("csr1_valid", 128'(csr_valid), 128'(1));
        chk("csr1_wa",    128'(csr_wa), 128'(12'h305));
        chk("csr1_cnt",   128'(retire_cnt), 128'(1));
        cyc();

        // reset with entries queued
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clear_in();
            set_lane(0, 1, 5'(10 + c), 64'(c), 0, 0, 0, 0, 0, 0, 0);
            if (c < 2) set_lane(1, 1, 5'(20 + c), 64'(c), 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        clear_in();
        chk("q5_empty", 128'(empty), 128'(0));
        stall = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rstcyc_rf_valid",  128'(rf_valid), 128'(0));
        chk("rstcyc_csr_valid", 128'(csr_valid), 128'(0));
        chk("rstcyc_cnt",       128'(retire_cnt), 128'(0));
        cyc();
        resetn = 1'b1;
        chk("postrst_empty", 128'(empty), 128'(1));
        chk("postrst_ready", 128'(in_ready), 128'(1));
        chk("postrst_rf",    128'(rf_valid), 128'(0));
        cyc();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            clear_in();
            stall  = ($urandom_range(0, 3) == 0);
            resetn = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_lane(i, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                             {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                             {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                             12'($urandom), {$urandom, $urandom});
            end
            cyc();
        end
        resetn = 1'b1;
        stall  = 1'b0;
        clear_in();
        repeat (6) cyc();
        chk("final_empty", 128'(empty), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
